// File: rtl/bayer_ctl_pkg.sv
// Shared definitions for the Bayer extract controller: FSM state encoding and
// the layout of the configuration word applied to the downstream extractor.
package bayer_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    localparam int CFG_COL_ODD = 0;
    localparam int CFG_ROW_ODD = 1;
    localparam int CFG_BYPASS  = 2;
    localparam int CFG_WIDTH   = 3;

    typedef logic [CFG_WIDTH-1:0] cfg_t;

    function automatic cfg_t cfg_pack(input logic col_odd, input logic row_odd, input logic bypass);
        cfg_t c;
        c              = '0;
        c[CFG_COL_ODD] = col_odd;
        c[CFG_ROW_ODD] = row_odd;
        c[CFG_BYPASS]  = bypass;
        return c;
    endfunction

endpackage

// File: rtl/bayer_frame_counter.sv
// Column/line position tracker for one video frame; flags malformed lines and
// reports the beat that closes the frame.
module bayer_frame_counter #(
    parameter int C_IMG_WBITS = 12,
    parameter int C_IMG_HBITS = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_clear,
    input  logic                   i_beat,
    input  logic                   i_last,
    input  logic [C_IMG_WBITS-1:0] i_width,
    input  logic [C_IMG_HBITS-1:0] i_height,
    output logic [C_IMG_WBITS-1:0] o_col,
    output logic [C_IMG_HBITS-1:0] o_line,
    output logic                   o_frame_end,
    output logic                   o_err_line
);

    logic [C_IMG_WBITS-1:0] r_col;
    logic [C_IMG_HBITS-1:0] r_line;
    logic                   r_err_line;
    logic                   w_col_end;
    logic                   w_line_last;

    assign w_col_end   = (r_col == i_width - C_IMG_WBITS'(1));
    assign w_line_last = (r_line == i_height - C_IMG_HBITS'(1));
    assign o_frame_end = i_beat & i_last & w_line_last;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!resetn || i_clear) begin
            r_col  <= '0;
            r_line <= '0;
        end else if (i_beat) begin
            if (i_last) begin
                r_col  <= '0;
                r_line <= w_line_last ? '0 : r_line + C_IMG_HBITS'(1);
            end else begin
                r_col  <= r_col + C_IMG_WBITS'(1);
            end
        end
    end

    // A line is malformed when tlast and the expected last column disagree.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err_line <= 1'b0;
        end else begin
            r_err_line <= i_beat & (i_last ^ w_col_end);
        end
    end

    assign o_col      = r_col;
    assign o_line     = r_line;
    assign o_err_line = r_err_line;

endmodule

// File: rtl/axis_bayer_extract_ctl.sv
// Frame-aligned gate in front of a Bayer extractor: waits for SOF, latches the
// requested phase/size, then passes whole frames with zero latency.
module axis_bayer_extract_ctl
    import bayer_ctl_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_en,
    input  logic                     req_col_odd,
    input  logic                     req_row_odd,
    input  logic                     req_bypass,
    input  logic [C_IMG_WBITS-1:0]   req_width,
    input  logic [C_IMG_HBITS-1:0]   req_height,
    output logic                     cur_col_odd,
    output logic                     cur_row_odd,
    output logic                     cur_bypass,
    output logic                     busy,
    output logic [31:0]              frame_cnt,
    output logic                     err_line,
    output logic                     err_frame,
    output logic                     err_cfg,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    state_t                 r_state;
    state_t                 w_state_next;
    cfg_t                   r_cur_cfg;
    logic [C_IMG_WBITS-1:0] r_width;
    logic [C_IMG_HBITS-1:0] r_height;
    logic [31:0]            r_frame_cnt;
    logic                   r_err_frame;
    logic                   r_err_cfg;

    logic                   w_s_ready;
    logic                   w_m_valid;
    logic                   w_latch;
    logic                   w_sof_err;
    logic                   w_cfg_err;
    logic                   w_cfg_ok;
    logic                   w_sof_misplaced;
    logic                   w_beat;
    logic                   w_frame_end;
    logic                   w_cnt_clear;
    logic [C_IMG_WBITS-1:0] w_col;
    logic [C_IMG_HBITS-1:0] w_line;

    assign w_cfg_ok = !req_width[0]  && (req_width  >= C_IMG_WBITS'(2)) &&
                      !req_height[0] && (req_height >= C_IMG_HBITS'(2));

    // An SOF anywhere but the first pixel restarts frame alignment on that beat.
    assign w_sof_misplaced = (r_state == ST_RUN) && s_axis_tvalid && s_axis_tuser &&
                             ((w_col != '0) || (w_line != '0));

    assign w_beat      = (r_state == ST_RUN) && !w_sof_misplaced && s_axis_tvalid && m_axis_tready;
    assign w_cnt_clear = (r_state != ST_RUN) || w_sof_err;

    bayer_frame_counter #(
        .C_IMG_WBITS (C_IMG_WBITS),
        .C_IMG_HBITS (C_IMG_HBITS)
    ) u_frame_counter (
        .clk         (clk),
        .resetn      (resetn),
        .i_clear     (w_cnt_clear),
        .i_beat      (w_beat),
        .i_last      (s_axis_tlast),
        .i_width     (r_width),
        .i_height    (r_height),
        .o_col       (w_col),
        .o_line      (w_line),
        .o_frame_end (w_frame_end),
        .o_err_line  (err_line)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        w_m_valid    = 1'b0;
        w_latch      = 1'b0;
        w_sof_err    = 1'b0;
        w_cfg_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_ready = 1'b1;
                if (req_en) w_state_next = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (!req_en) begin
                    w_s_ready    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_err_cfg) begin
                    w_s_ready = 1'b1;  // drop the SOF beat whose size was rejected
                end else if (s_axis_tvalid && s_axis_tuser) begin
                    w_latch = 1'b1;
                    if (w_cfg_ok) w_state_next = ST_RUN;
                    else          w_cfg_err    = 1'b1;
                end else begin
                    w_s_ready = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_sof_misplaced) begin
                    if (m_axis_tready) begin
                        w_sof_err    = 1'b1;
                        w_state_next = ST_WAIT_SOF;
                    end
                end else begin
                    w_m_valid = s_axis_tvalid;
                    w_s_ready = m_axis_tready;
                    if (w_frame_end) w_state_next = req_en ? ST_WAIT_SOF : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cur_cfg   <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_frame_cnt <= '0;
            r_err_frame <= 1'b0;
            r_err_cfg   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_err_frame <= w_sof_err;
            r_err_cfg   <= w_cfg_err;
            if (w_latch) begin
                r_cur_cfg <= cfg_pack(req_col_odd, req_row_odd, req_bypass);
                r_width   <= req_width;
                r_height  <= req_height;
            end
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    // Handshake outputs are forced low while reset is held, not just after the edge.
    assign s_axis_tready = resetn & w_s_ready;
    assign m_axis_tvalid = resetn & w_m_valid;
    assign busy          = resetn & (r_state == ST_RUN);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;

    assign cur_col_odd = r_cur_cfg[CFG_COL_ODD];
    assign cur_row_odd = r_cur_cfg[CFG_ROW_ODD];
    assign cur_bypass  = r_cur_cfg[CFG_BYPASS];
    assign frame_cnt   = r_frame_cnt;
    assign err_frame   = r_err_frame;
    assign err_cfg     = r_err_cfg;

endmodule

// File: tb/tb_axis_bayer_extract_ctl.sv
// Directed bench for axis_bayer_extract_ctl: frame gating, phase latching,
// line/frame/config errors, back-pressure and mid-frame reset.
module tb_axis_bayer_extract_ctl;

    localparam int PW = 8;
    localparam int WB = 12;
    localparam int HB = 12;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_en = 1'b0, req_col_odd = 1'b0, req_row_odd = 1'b0, req_bypass = 1'b0;
    logic [WB-1:0] req_width = '0;
    logic [HB-1:0] req_height = '0;
    logic          cur_col_odd, cur_row_odd, cur_bypass, busy;
    logic [31:0]   frame_cnt;
    logic          err_line, err_frame, err_cfg;
    logic          s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
    logic [PW-1:0] s_axis_tdata = '0;
    logic          s_axis_tready;
    logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tready = 1'b1;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_err_line = 0, n_err_frame = 0, n_err_cfg = 0;
    bit            rand_ready = 1'b0;
    logic [9:0]    got[$];
    logic [9:0]    exp_q[$];

    axis_bayer_extract_ctl #(
        .C_PIXEL_WIDTH (PW),
        .C_IMG_WBITS   (WB),
        .C_IMG_HBITS   (HB)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_en        (req_en),
        .req_col_odd   (req_col_odd),
        .req_row_odd   (req_row_odd),
        .req_bypass    (req_bypass),
        .req_width     (req_width),
        .req_height    (req_height),
        .cur_col_odd   (cur_col_odd),
        .cur_row_odd   (cur_row_odd),
        .cur_bypass    (cur_bypass),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .err_line      (err_line),
        .err_frame     (err_frame),
        .err_cfg       (err_cfg),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output beats and error pulses are observed mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (err_line)  n_err_line++;
        if (err_frame) n_err_frame++;
        if (err_cfg)   n_err_cfg++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    function automatic int stream_diff(input int g0);
        int d = 0;
        if (got.size() - g0 != exp_q.size()) d++;
        for (int i = 0; i < exp_q.size(); i++)
            if (g0 + i >= got.size() || got[g0 + i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic send_beat(input logic [PW-1:0] d, input logic u, input logic l, output int stalls);
        stalls = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
        forever begin
            @(negedge clk);
            if (s_axis_tready) begin
                @(posedge clk); #1;
                break;
            end
            stalls++;
            if (stalls > 200) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: beat %h stalled %0d cycles, required <= 200", d, stalls);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic send_pix(input int idx, input int w, input logic [PW-1:0] base, output int stalls);
        logic [PW-1:0] d;
        logic          u, l;
        d = base + PW'(idx);
        u = (idx == 0);
        l = ((idx % w) == w - 1);
        send_beat(d, u, l, stalls);
        exp_q.push_back({u, l, d});
    endtask

    task automatic send_frame(input int w, input int h, input logic [PW-1:0] base, output int sof_stalls);
        int st;
        sof_stalls = 0;
        for (int i = 0; i < w * h; i++) begin
            send_pix(i, w, base, st);
            if (i == 0) sof_stalls = st;
        end
    endtask

    task automatic set_req(input logic en, input logic c, input logic r, input logic b, input int w, input int h);
        req_en = en; req_col_odd = c; req_row_odd = r; req_bypass = b;
        req_width = WB'(w); req_height = HB'(h);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_axis_tready); end
        n_tests++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_axis_tvalid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        n_tests++; if ({cur_col_odd, cur_row_odd, cur_bypass} !== 3'b000) begin n_fail++; $display("FAIL reset_cur: got %b want 000", {cur_col_odd, cur_row_odd, cur_bypass}); end
        n_tests++; if ({err_line, err_frame, err_cfg} !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", {err_line, err_frame, err_cfg}); end
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_basic();
        int g0, st, e0;
        set_req(1'b1, 1'b1, 1'b0, 1'b0, 4, 2);
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL idle_state: busy=%b ready=%b want 0/1", busy, s_axis_tready); end
        @(posedge clk); #1;
        exp_q.delete(); g0 = got.size(); e0 = n_err_line + n_err_frame + n_err_cfg;
        for (int i = 0; i < 3; i++) begin
            send_beat(PW'(8'hE0 + i), 1'b0, 1'b0, st);
            n_tests++; if (st !== 0) begin n_fail++; $display("FAIL junk_stall_%0d: got %0d want 0", i, st); end
        end
        n_tests++; if (got.size() !== g0) begin n_fail++; $display("FAIL junk_dropped: got %0d beats out want 0", got.size() - g0); end
        send_frame(4, 2, 8'h10, st);
        n_tests++; if (st !== 1) begin n_fail++; $display("FAIL sof_stall: got %0d want 1", st); end
        n_tests++; if ({cur_col_odd, cur_row_odd, cur_bypass} !== 3'b100) begin n_fail++; $display("FAIL basic_cur: got %b want 100", {cur_col_odd, cur_row_odd, cur_bypass}); end
        n_tests++; if (stream_diff(g0) !== 0) begin n_fail++; $display("FAIL basic_stream: mismatches %0d want 0", stream_diff(g0)); end
        n_tests++; if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
        n_tests++; if (n_err_line + n_err_frame + n_err_cfg !== e0) begin n_fail++; $display("FAIL basic_no_err: got %0d pulses want 0", n_err_line + n_err_frame + n_err_cfg - e0); end
    endtask

    task automatic test_phase_hold();
        int g0, st;
        exp_q.delete(); g0 = got.size();
        for (int i = 0; i < 4; i++) send_pix(i, 4, 8'h20, st);
        req_col_odd = 1'b0; req_row_odd = 1'b1;
        @(negedge clk);
        n_tests++; if ({cur_col_odd, cur_row_odd} !== 2'b10) begin n_fail++; $display("FAIL hold_mid_cur: got %b want 10", {cur_col_odd, cur_row_odd}); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        for (int i = 4; i < 8; i++) send_pix(i, 4, 8'h20, st);
        n_tests++; if ({cur_col_odd, cur_row_odd} !== 2'b10) begin n_fail++; $display("FAIL hold_end_cur: got %b want 10", {cur_col_odd, cur_row_odd}); end
        n_tests++; if (frame_cnt !== 32'd2) begin n_fail++; $display("FAIL hold_frame_cnt: got %0d want 2", frame_cnt); end
        send_frame(4, 2, 8'h30, st);
        n_tests++; if ({cur_col_odd, cur_row_odd} !== 2'b01) begin n_fail++; $display("FAIL hold_new_cur: got %b want 01", {cur_col_odd, cur_row_odd}); end
        n_tests++; if (stream_diff(g0) !== 0) begin n_fail++; $display("FAIL hold_stream: mismatches %0d want 0", stream_diff(g0)); end
        n_tests++; if (frame_cnt !== 32'd3) begin n_fail++; $display("FAIL hold_frame_cnt2: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_line_err();
        int g0, st, e0;
        logic [9:0] beats [7];
        beats = '{10'h240, 10'h041, 10'h142, 10'h043, 10'h044, 10'h045, 10'h146};
        exp_q.delete(); g0 = got.size(); e0 = n_err_line;
        for (int i = 0; i < 7; i++) begin
            send_beat(beats[i][7:0], beats[i][9], beats[i][8], st);
            exp_q.push_back(beats[i]);
            if (i == 2) begin
                n_tests++; if (frame_cnt !== 32'd3) begin n_fail++; $display("FAIL line_short_no_end: got %0d want 3", frame_cnt); end
            end
        end
        @(negedge clk);
        n_tests++; if (n_err_line - e0 !== 1) begin n_fail++; $display("FAIL line_err_pulse: got %0d want 1", n_err_line - e0); end
        n_tests++; if (frame_cnt !== 32'd4) begin n_fail++; $display("FAIL line_frame_cnt: got %0d want 4", frame_cnt); end
        n_tests++; if (stream_diff(g0) !== 0) begin n_fail++; $display("FAIL line_stream: mismatches %0d want 0", stream_diff(g0)); end
        @(posedge clk); #1;
    endtask

    task automatic test_sof_err();
        int g0, st, f0;
        do_reset();
        n_tests++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL sof_reset_cnt: got %0d want 0", frame_cnt); end
        exp_q.delete(); g0 = got.size(); f0 = n_err_frame;
        send_pix(0, 4, 8'h50, st);
        send_pix(1, 4, 8'h50, st);
        send_frame(4, 2, 8'h60, st);
        n_tests++; if (st !== 2) begin n_fail++; $display("FAIL sof_err_stall: got %0d want 2", st); end
        n_tests++; if (n_err_frame - f0 !== 1) begin n_fail++; $display("FAIL sof_err_pulse: got %0d want 1", n_err_frame - f0); end
        n_tests++; if (stream_diff(g0) !== 0) begin n_fail++; $display("FAIL sof_stream: mismatches %0d want 0", stream_diff(g0)); end
        n_tests++; if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL sof_frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_backpressure();
        int g0, st;
        do_reset();
        exp_q.delete(); g0 = got.size();
        rand_ready = 1'b1;
        send_frame(4, 2, 8'h70, st);
        send_frame(4, 2, 8'h80, st);
        send_frame(4, 2, 8'h90, st);
        rand_ready = 1'b0;
        n_tests++; if (got.size() - g0 !== 24) begin n_fail++; $display("FAIL bp_count: got %0d beats want 24", got.size() - g0); end
        n_tests++; if (stream_diff(g0) !== 0) begin n_fail++; $display("FAIL bp_stream: mismatches %0d want 0", stream_diff(g0)); end
        n_tests++; if (frame_cnt !== 32'd3) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d want 3", frame_cnt); end
    endtask

    task automatic test_cfg_err_and_reset();
        int g0, st, c0;
        set_req(1'b1, 1'b1, 1'b1, 1'b1, 3, 2);
        g0 = got.size(); c0 = n_err_cfg;
        send_beat(8'hA0, 1'b1, 1'b0, st);
        n_tests++; if (st !== 1) begin n_fail++; $display("FAIL cfg_sof_stall: got %0d want 1", st); end
        send_beat(8'hA1, 1'b0, 1'b0, st);
        send_beat(8'hA2, 1'b0, 1'b1, st);
        @(negedge clk);
        n_tests++; if (n_err_cfg - c0 !== 1) begin n_fail++; $display("FAIL cfg_err_pulse: got %0d want 1", n_err_cfg - c0); end
        n_tests++; if (got.size() !== g0) begin n_fail++; $display("FAIL cfg_nothing_out: got %0d beats want 0", got.size() - g0); end
        n_tests++; if (busy !== 1'b0 || frame_cnt !== 32'd3) begin n_fail++; $display("FAIL cfg_state: busy=%b cnt=%0d want 0/3", busy, frame_cnt); end
        @(posedge clk); #1;
        req_width = WB'(4);
        send_beat(8'hB0, 1'b1, 1'b0, st);
        send_beat(8'hB1, 1'b0, 1'b0, st);
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'hB2;
        resetn = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_run_hs: ready=%b valid=%b busy=%b want 000", s_axis_tready, m_axis_tvalid, busy); end
        n_tests++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_run_cnt: got %0d want 0", frame_cnt); end
        n_tests++; if ({cur_col_odd, cur_row_odd, cur_bypass} !== 3'b000) begin n_fail++; $display("FAIL rst_run_cur: got %b want 000", {cur_col_odd, cur_row_odd, cur_bypass}); end
        s_axis_tvalid = 1'b0;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete(); g0 = got.size();
        send_beat(8'hC0, 1'b0, 1'b0, st);
        send_beat(8'hC1, 1'b0, 1'b1, st);
        n_tests++; if (got.size() !== g0) begin n_fail++; $display("FAIL rst_no_partial: got %0d beats want 0", got.size() - g0); end
        send_frame(4, 2, 8'hD0, st);
        n_tests++; if (stream_diff(g0) !== 0) begin n_fail++; $display("FAIL rst_resume_stream: mismatches %0d want 0", stream_diff(g0)); end
        n_tests++; if (frame_cnt !== 32'd1 || cur_bypass !== 1'b1) begin n_fail++; $display("FAIL rst_resume: cnt=%0d bypass=%b want 1/1", frame_cnt, cur_bypass); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_phase_hold();
        test_line_err();
        test_sof_err();
        test_backpressure();
        test_cfg_err_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
